// File: rtl/debouncer_gray_in_pkg.sv
// -----------------------------------------------------------------------------
// debouncer_gray_in_pkg
// Shared definitions for the Gray-code input conditioning stage, the decoder
// top that consumes it, and their benches.
//   ESTABLE / VALIDANDO : encoding of the one-bit debounce state
//   GRAY_WIDTH          : default number of Gray code bits
// -----------------------------------------------------------------------------
package debouncer_gray_in_pkg;

  localparam logic ESTABLE   = 1'b0;
  localparam logic VALIDANDO = 1'b1;

  localparam int GRAY_WIDTH = 4;

endpackage

// File: rtl/debouncer_gray_in_sincronizador_2ff.sv
// -----------------------------------------------------------------------------
// sincronizador_2ff
// Two-flop synchroniser per bit for asynchronous inputs (switches, buttons).
// Reusable for any async bus in the design.
//   clk_pi   : destination clock
//   rst_pi   : synchronous active-low reset, clears both stages to 0
//   async_pi : raw asynchronous bus
//   sinc_po  : bus synchronised to clk_pi (two cycles of latency)
// -----------------------------------------------------------------------------
module sincronizador_2ff
  import debouncer_gray_in_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic [WIDTH-1:0] async_pi,
  output logic [WIDTH-1:0] sinc_po
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sinc_r;

  // Two-stage capture: meta_r may go metastable, sinc_r gets a full cycle to settle.
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      meta_r <= {WIDTH{1'b0}};
      sinc_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= async_pi;
      sinc_r <= meta_r;
    end
  end

  assign sinc_po = sinc_r;

endmodule

// File: rtl/debouncer_gray_in.sv
// -----------------------------------------------------------------------------
// debouncer_gray_in
// Synchronises the raw slide-switch Gray code and only forwards a new value
// once it has been stable for 2**CNT_BITS consecutive cycles after sync.
//   WIDTH           : number of Gray code bits
//   CNT_BITS        : stability counter width (MAX = 2**CNT_BITS - 1)
//   clk_pi          : system clock
//   rst_pi          : synchronous active-low reset
//   codigo_gray_pi  : raw asynchronous switch bits
//   codigo_gray_po  : debounced Gray code (registered)
//   nuevo_codigo_po : one-cycle strobe when codigo_gray_po takes a new value
//   estable_po      : high when no candidate change is being validated
// -----------------------------------------------------------------------------
module debouncer_gray_in
  import debouncer_gray_in_pkg::*;
#(
  parameter int WIDTH    = GRAY_WIDTH,
  parameter int CNT_BITS = 16
) (
  input  logic             clk_pi,
  input  logic             rst_pi,
  input  logic [WIDTH-1:0] codigo_gray_pi,
  output logic [WIDTH-1:0] codigo_gray_po,
  output logic             nuevo_codigo_po,
  output logic             estable_po
);

  localparam logic [CNT_BITS-1:0] MAX     = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_UNO = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    sinc_s;

  logic                estado_r;
  logic [WIDTH-1:0]    candidato_r;
  logic [CNT_BITS-1:0] cnt_r;
  logic [WIDTH-1:0]    codigo_r;
  logic                nuevo_r;

  logic                estado_nxt_s;
  logic [WIDTH-1:0]    candidato_nxt_s;
  logic [CNT_BITS-1:0] cnt_nxt_s;
  logic [WIDTH-1:0]    codigo_nxt_s;
  logic                nuevo_nxt_s;
  logic                estable_s;

  sincronizador_2ff #(
    .WIDTH (WIDTH)
  ) u_sinc (
    .clk_pi   (clk_pi),
    .rst_pi   (rst_pi),
    .async_pi (codigo_gray_pi),
    .sinc_po  (sinc_s)
  );

  // State register: reset wins over any pending validation.
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      estado_r <= ESTABLE;
    end else begin
      estado_r <= estado_nxt_s;
    end
  end

  // Datapath registers: candidate, stability counter and the registered outputs.
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      candidato_r <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_BITS{1'b0}};
      codigo_r    <= {WIDTH{1'b0}};
      nuevo_r     <= 1'b0;
    end else begin
      candidato_r <= candidato_nxt_s;
      cnt_r       <= cnt_nxt_s;
      codigo_r    <= codigo_nxt_s;
      nuevo_r     <= nuevo_nxt_s;
    end
  end

  // Next-state logic: the strobe defaults low so it lasts only the cycle after an accept.
  always_comb begin
    estado_nxt_s    = estado_r;
    candidato_nxt_s = candidato_r;
    cnt_nxt_s       = cnt_r;
    codigo_nxt_s    = codigo_r;
    nuevo_nxt_s     = 1'b0;
    case (estado_r)
      ESTABLE: begin
        if (sinc_s != codigo_r) begin
          candidato_nxt_s = sinc_s;
          cnt_nxt_s       = {CNT_BITS{1'b0}};
          estado_nxt_s    = VALIDANDO;
        end else begin
          estado_nxt_s = ESTABLE;
        end
      end
      VALIDANDO: begin
        if (sinc_s == codigo_r) begin
          // Glitch fell back to the committed value: drop the candidate.
          cnt_nxt_s    = {CNT_BITS{1'b0}};
          estado_nxt_s = ESTABLE;
        end else if (sinc_s != candidato_r) begin
          // Input moved again: the new value gets a full window of its own.
          candidato_nxt_s = sinc_s;
          cnt_nxt_s       = {CNT_BITS{1'b0}};
        end else if (cnt_r == MAX) begin
          codigo_nxt_s = candidato_r;
          nuevo_nxt_s  = 1'b1;
          cnt_nxt_s    = {CNT_BITS{1'b0}};
          estado_nxt_s = ESTABLE;
        end else begin
          // Never wraps: reaching MAX always accepts or restarts above.
          cnt_nxt_s = cnt_r + CNT_UNO;
        end
      end
      default: begin
        cnt_nxt_s    = {CNT_BITS{1'b0}};
        estado_nxt_s = ESTABLE;
      end
    endcase
  end

  // Output decode: stability flag straight from the state register.
  always_comb begin
    estable_s = 1'b0;
    if (estado_r == ESTABLE) begin
      estable_s = 1'b1;
    end else begin
      estable_s = 1'b0;
    end
  end

  assign codigo_gray_po  = codigo_r;
  assign nuevo_codigo_po = nuevo_r;
  assign estable_po      = estable_s;

endmodule

// File: tb/tb_debouncer_gray_in.sv
module tb_debouncer_gray_in;

  localparam int W    = 4;
  localparam int CB   = 3;
  localparam int MAX  = (1 << CB) - 1;
  // Edge evaluations a value must be seen on the synchronised bus: the detect
  // edge plus MAX+1 counting/accept edges.
  localparam int RUN_NEEDED = MAX + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] raw = 4'b0000;
  logic [W-1:0] codigo;
  logic         nuevo;
  logic         estable;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  debouncer_gray_in #(
    .WIDTH    (W),
    .CNT_BITS (CB)
  ) dut (
    .clk_pi          (clk),
    .rst_pi          (rst_n),
    .codigo_gray_pi  (raw),
    .codigo_gray_po  (codigo),
    .nuevo_codigo_po (nuevo),
    .estable_po      (estable)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: the synchronised bus is the raw input two samples late;
  // a value is committed once it has been seen unchanged on RUN_NEEDED
  // consecutive edges while differing from the committed output.
  logic [W-1:0] m_d1 = 4'b0000, m_d2 = 4'b0000, m_out = 4'b0000, m_run_val = 4'b0000;
  int           m_run = 0;
  logic         m_pulse = 1'b0, m_stable = 1'b1, m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [W-1:0] s;
    logic [W-1:0] out_n;
    int           run_n;
    logic         pulse_n;
    if (!rst_n) begin
      m_d1      <= 4'b0000;
      m_d2      <= 4'b0000;
      m_out     <= 4'b0000;
      m_run_val <= 4'b0000;
      m_run     <= 0;
      m_pulse   <= 1'b0;
      m_stable  <= 1'b1;
    end else begin
      s = m_d2;
      if (m_run > 0 && s == m_run_val) run_n = (m_run < 1000) ? m_run + 1 : m_run;
      else run_n = 1;
      out_n   = m_out;
      pulse_n = 1'b0;
      if (s != m_out && run_n >= RUN_NEEDED) begin
        out_n   = s;
        pulse_n = 1'b1;
      end
      m_run_val <= s;
      m_run     <= run_n;
      m_out     <= out_n;
      m_pulse   <= pulse_n;
      m_stable  <= (s == out_n);
      m_d2      <= m_d1;
      m_d1      <= raw;
    end
    m_valid <= 1'b1;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_codigo", codigo, m_out);
      check("model_pulse", nuevo, m_pulse);
      check("model_estable", estable, m_stable);
    end
  end

  initial begin : stim
    int pulses;
    logic saw_0001;

    // 1: reset with non-zero switches, then initial load.
    rst_n = 1'b0;
    raw   = 4'b1010;
    step(3);
    check("s1_rst_codigo", codigo, 4'b0000);
    check("s1_rst_pulse", nuevo, 1'b0);
    check("s1_rst_estable", estable, 1'b1);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("s1_codigo", codigo, (k >= 11) ? 4'b1010 : 4'b0000);
      check("s1_pulse", nuevo, (k == 11));
    end

    // 2: clean step 0000 -> 0011.
    raw = 4'b0000;
    step(14);
    raw = 4'b0011;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("s2_codigo", codigo, (k >= 11) ? 4'b0011 : 4'b0000);
      check("s2_pulse", nuevo, (k == 11));
      check("s2_estable", estable, (k >= 3 && k <= 10) ? 1'b0 : 1'b1);
    end

    // 3: bounce on bit0 every 3 cycles, then settle at 0001.
    raw = 4'b0000;
    step(14);
    for (int t = 0; t < 8; t++) begin
      raw[0] = ~raw[0];
      for (int c = 0; c < 3; c++) begin
        step(1);
        check("s3_bounce_pulse", nuevo, 1'b0);
        check("s3_bounce_codigo", codigo, 4'b0000);
      end
    end
    raw = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("s3_codigo", codigo, (k >= 11) ? 4'b0001 : 4'b0000);
      check("s3_pulse", nuevo, (k == 11));
    end

    // 4: short glitch to 0100 is rejected.
    raw = 4'b0000;
    step(14);
    raw = 4'b0100;
    step(4);
    raw = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("s4_pulse", nuevo, 1'b0);
      check("s4_codigo", codigo, 4'b0000);
    end
    check("s4_estable", estable, 1'b1);

    // 5: candidate switches from 0001 to 0011 before acceptance.
    pulses   = 0;
    saw_0001 = 1'b0;
    raw = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      if (nuevo) pulses++;
      if (codigo == 4'b0001) saw_0001 = 1'b1;
    end
    raw = 4'b0011;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      if (nuevo) pulses++;
      if (codigo == 4'b0001) saw_0001 = 1'b1;
    end
    check("s5_pulses", pulses, 1);
    check("s5_no_0001", saw_0001, 1'b0);
    check("s5_codigo", codigo, 4'b0011);

    // 6: reset during validation discards the candidate; fresh load afterwards.
    raw = 4'b1111;
    step(5);
    rst_n = 1'b0;
    step(1);
    check("s6_rst_codigo", codigo, 4'b0000);
    check("s6_rst_pulse", nuevo, 1'b0);
    check("s6_rst_estable", estable, 1'b1);
    step(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      check("s6_codigo", codigo, (k >= 11) ? 4'b1111 : 4'b0000);
      check("s6_pulse", nuevo, (k == 11));
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
